// File: rtl/float_class_arbiter_if.sv
// float_class_arbiter_if
//   Handshake bundle between two operand producers, the classifier arbiter
//   and one downstream consumer.
//
//   Signals:
//     in0_valid/in0_num/in0_ready  requester 0 valid/ready channel
//     in1_valid/in1_num/in1_ready  requester 1 valid/ready channel
//     out_valid/out_ready          result channel to the consumer
//     out_type                     one-hot class of the buffered word
//     out_id                       requester that supplied the buffered word
//     out_num                      buffered original word
//
//   Modports:
//     slave   arbiter side (takes requests, produces results)
//     master  environment side (producers and consumer)
interface float_class_arbiter_if;
  logic        in0_valid;
  logic [31:0] in0_num;
  logic        in0_ready;
  logic        in1_valid;
  logic [31:0] in1_num;
  logic        in1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_type;
  logic        out_id;
  logic [31:0] out_num;

  modport slave (
    input  in0_valid, in0_num, in1_valid, in1_num, out_ready,
    output in0_ready, in1_ready, out_valid, out_type, out_id, out_num
  );

  modport master (
    output in0_valid, in0_num, in1_valid, in1_num, out_ready,
    input  in0_ready, in1_ready, out_valid, out_type, out_id, out_num
  );
endinterface

// File: rtl/float_class_arbiter.sv
// float_class_arbiter
//   Shares one IEEE-754 single-precision classifier between two requesters.
//   A round-robin arbiter accepts at most one word per cycle; the word is
//   classified (zero / normal / subnormal / infinity / NaN, sign ignored)
//   and held with its requester ID in a one-entry output buffer that
//   supports full throughput under consumer backpressure.
//
//   Ports:
//     clk        system clock, all state on the rising edge
//     reset      synchronous, active-high reset
//     bus        float_class_arbiter_if.slave (request and result channels)
//     stats_clr  synchronous clear of the per-class counters
//     cnt_zero, cnt_norm, cnt_sub, cnt_inf, cnt_nan
//                per-class accept counters, CNT_W bits each, saturating
//
//   Parameters:
//     CNT_W      width of each statistics counter
//
//   Build option:
//     FLOAT_CLASS_STATS_EN  when defined, builds the saturating per-class
//                           counters. When undefined, no counter flops exist,
//                           cnt_* read 0 and stats_clr is ignored.
//
//   State   | meaning
//   --------+------------------------------------------------
//   EMPTY   | output buffer holds nothing, out_valid = 0
//   FULL    | output buffer holds a classified word, out_valid = 1
module float_class_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  float_class_arbiter_if.slave bus,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   cnt_zero,
  output logic [CNT_W-1:0]   cnt_norm,
  output logic [CNT_W-1:0]   cnt_sub,
  output logic [CNT_W-1:0]   cnt_inf,
  output logic [CNT_W-1:0]   cnt_nan
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [4:0] CLS_ZERO = 5'b00001;
  localparam logic [4:0] CLS_NORM = 5'b00010;
  localparam logic [4:0] CLS_SUB  = 5'b00100;
  localparam logic [4:0] CLS_INF  = 5'b01000;
  localparam logic [4:0] CLS_NAN  = 5'b10000;

  function automatic logic [4:0] classify(input logic [31:0] num);
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    logic [4:0]  cls;
    exp_f = num[30:23];
    man_f = num[22:0];
    if (exp_f == 8'h00) begin
      cls = (man_f == 23'd0) ? CLS_ZERO : CLS_SUB;
    end else if (exp_f == 8'hFF) begin
      cls = (man_f == 23'd0) ? CLS_INF : CLS_NAN;
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic        last_q;      // requester granted at the most recent accept
  logic        space;
  logic        gnt_valid;
  logic        gnt_id;
  logic        accept;
  logic [31:0] acc_num;
  logic [4:0]  acc_type;

  logic [4:0]  type_q;
  logic        id_q;
  logic [31:0] num_q;

  // The buffer can take a word when it is empty or is being drained
  // this cycle.
  assign space = (state_q == EMPTY) | bus.out_ready;

  // Grant looks only at the valids and the pointer, never at the readies,
  // so there is no combinational loop through a requester.
  always_comb begin
    gnt_valid = bus.in0_valid | bus.in1_valid;
    gnt_id    = 1'b0;
    if (bus.in0_valid & bus.in1_valid) begin
      gnt_id = ~last_q;
    end else if (bus.in1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Reset blocks any accept in the cycle it is asserted.
  assign accept        = ~reset & space & gnt_valid;
  assign bus.in0_ready = ~reset & space & gnt_valid & (gnt_id == 1'b0);
  assign bus.in1_ready = ~reset & space & gnt_valid & (gnt_id == 1'b1);

  assign acc_num  = gnt_id ? bus.in1_num : bus.in0_num;
  assign acc_type = classify(acc_num);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= gnt_id;
      end
    end
  end

  // Output buffer: loaded only on accept, otherwise held stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      type_q <= 5'b00000;
      id_q   <= 1'b0;
      num_q  <= 32'd0;
    end else if (accept) begin
      type_q <= acc_type;
      id_q   <= gnt_id;
      num_q  <= acc_num;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_type  = type_q;
  assign bus.out_id    = id_q;
  assign bus.out_num   = num_q;

`ifdef FLOAT_CLASS_STATS_EN
  logic [4:0][CNT_W-1:0] cnt_q;

  // Index order follows the one-hot bit positions of the class code.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 5; i++) begin
        if (acc_type[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_zero = cnt_q[0];
  assign cnt_norm = cnt_q[1];
  assign cnt_sub  = cnt_q[2];
  assign cnt_inf  = cnt_q[3];
  assign cnt_nan  = cnt_q[4];
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;

  assign cnt_zero = '0;
  assign cnt_norm = '0;
  assign cnt_sub  = '0;
  assign cnt_inf  = '0;
  assign cnt_nan  = '0;
`endif

endmodule

// File: tb/tb_float_class_arbiter.sv
module tb_float_class_arbiter;

`ifdef FLOAT_CLASS_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  typedef struct {
    logic [4:0]  cls;
    logic        id;
    logic [31:0] num;
  } exp_t;

  typedef struct {
    logic        v0;
    logic [31:0] n0;
    logic        v1;
    logic [31:0] n1;
    logic        ordy;
    logic        r0;
    logic        r1;
    logic        ov;
  } vec_t;

  logic clk;
  logic reset;
  logic stats_clr;
  logic [TB_CNT_W-1:0] cnt_zero, cnt_norm, cnt_sub, cnt_inf, cnt_nan;

  float_class_arbiter_if bus();

  float_class_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .stats_clr(stats_clr),
    .cnt_zero (cnt_zero),
    .cnt_norm (cnt_norm),
    .cnt_sub  (cnt_sub),
    .cnt_inf  (cnt_inf),
    .cnt_nan  (cnt_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];
  logic [TB_CNT_W-1:0] m_cnt [5];
  vec_t vecs [24];

  function automatic logic [4:0] ref_class(input logic [31:0] w);
    logic [7:0] e;
    logic       mz;
    e  = w[30:23];
    mz = (w[22:0] == 23'd0);
    case (e)
      8'h00:   return mz ? 5'b00001 : 5'b00100;
      8'hFF:   return mz ? 5'b01000 : 5'b10000;
      default: return 5'b00010;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic stat_inc(input logic [31:0] w);
`ifdef FLOAT_CLASS_STATS_EN
    logic [4:0] c;
    c = ref_class(w);
    for (int i = 0; i < 5; i++) begin
      if (c[i] && m_cnt[i] != {TB_CNT_W{1'b1}}) m_cnt[i] = m_cnt[i] + 1'b1;
    end
`else
    if (w === 32'hxxxx_xxxx) $display("stat_inc unknown word");
`endif
  endtask

  task automatic stat_clear();
    for (int i = 0; i < 5; i++) m_cnt[i] = '0;
  endtask

  // One clock cycle: drive just after a rising edge, check at the falling
  // edge, then advance the scoreboard and counter model.
  task automatic step(input logic v0, input logic [31:0] n0,
                      input logic v1, input logic [31:0] n1,
                      input logic ordy, input logic clr, input logic rst,
                      input logic er0, input logic er1, input logic eov);
    exp_t e;
    bus.in0_valid = v0;
    bus.in0_num   = n0;
    bus.in1_valid = v1;
    bus.in1_num   = n1;
    bus.out_ready = ordy;
    stats_clr     = clr;
    reset         = rst;
    @(negedge clk);
    chk("in0_ready", {31'd0, bus.in0_ready}, {31'd0, er0});
    chk("in1_ready", {31'd0, bus.in1_ready}, {31'd0, er1});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, eov});
    if (eov) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q[0];
        chk("out_type", {27'd0, bus.out_type}, {27'd0, e.cls});
        chk("out_id",   {31'd0, bus.out_id},   {31'd0, e.id});
        chk("out_num",  bus.out_num,           e.num);
      end
    end
    chk("cnt_zero", 32'(cnt_zero), 32'(m_cnt[0]));
    chk("cnt_norm", 32'(cnt_norm), 32'(m_cnt[1]));
    chk("cnt_sub",  32'(cnt_sub),  32'(m_cnt[2]));
    chk("cnt_inf",  32'(cnt_inf),  32'(m_cnt[3]));
    chk("cnt_nan",  32'(cnt_nan),  32'(m_cnt[4]));
    if (rst) begin
      sb_q.delete();
      stat_clear();
    end else begin
      if (eov && ordy && sb_q.size() > 0) void'(sb_q.pop_front());
      if (v0 && er0) begin
        sb_q.push_back('{ref_class(n0), 1'b0, n0});
        stat_inc(n0);
      end
      if (v1 && er1) begin
        sb_q.push_back('{ref_class(n1), 1'b1, n1});
        stat_inc(n1);
      end
`ifdef FLOAT_CLASS_STATS_EN
      if (clr) stat_clear();
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic eov);
    step(1'b0, 32'd0, 1'b0, 32'd0, ordy, 1'b0, 1'b0, 1'b0, 1'b0, eov);
  endtask

  initial begin
    //            v0    n0             v1    n1             ordy  r0    r1    ov
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'h3F80_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 32'h7F80_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h4049_0FDB, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'hFF80_0000, 1'b1, 32'h0080_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 32'h7F7F_FFFF, 1'b1, 32'h807F_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'h3F80_0000, 1'b1, 32'h7F80_0001, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'hC049_0FDB, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'h1234_5678, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 32'h1234_5678, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 32'h1234_5678, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 32'h8000_0000, 1'b1, 32'h807F_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 32'h0,         1'b1, 32'hFF80_0001, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[23] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1};

    stat_clear();
    bus.in0_valid = 1'b0;
    bus.in0_num   = 32'd0;
    bus.in1_valid = 1'b0;
    bus.in1_num   = 32'd0;
    bus.out_ready = 1'b0;
    stats_clr     = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    #1;

    // Reset cycle with both requesters valid: nothing may be accepted.
    step(1'b1, 32'h3F80_0000, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_out_type", {27'd0, bus.out_type}, 32'd0);
    chk("rst_out_id",   {31'd0, bus.out_id},   32'd0);
    chk("rst_out_num",  bus.out_num,           32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].v0, vecs[i].n0, vecs[i].v1, vecs[i].n1, vecs[i].ordy,
           1'b0, 1'b0, vecs[i].r0, vecs[i].r1, vecs[i].ov);
    end

    // Reset while FULL with both requesters valid drops the buffered word.
    step(1'b1, 32'h3F80_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_out_type",  {27'd0, bus.out_type},  32'd0);
    chk("midrst_out_num",   bus.out_num,            32'd0);
    idle(1'b1, 1'b0);

    // Counter saturation, then clear colliding with an accept.
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3F80_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h4000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hC000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0080_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
`ifdef FLOAT_CLASS_STATS_EN
    chk("cnt_norm_sat", 32'(cnt_norm), 32'd3);
`else
    chk("cnt_norm_off", 32'(cnt_norm), 32'd0);
`endif
    step(1'b1, 32'h4000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cnt_norm_clr", 32'(cnt_norm), 32'd0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
